// File: rtl/cam_capture_scaled.sv
// cam_capture_scaled: OV7670 byte-stream capture with 2^DEC_LOG2 decimation,
// per-frame colour conversion and linear frame-buffer write addressing.
//
// Ports:
//   clk, rst        capture clock (camera PCLK), synchronous active-high reset
//   CAM_px_data     camera data byte, two bytes per pixel
//   CAM_href        line valid
//   CAM_vsync       frame sync, high between frames
//   capture_en      arm capture of the next frame (sampled at frame start)
//   mode            0/3 RGB565, 1 RGB444 (xR GB), 2 YUYV luma (sampled at frame start)
//   DP_RAM_regW     buffer write enable, one cycle per kept pixel
//   DP_RAM_addr_in  buffer write address
//   DP_RAM_data_in  buffer write data (DW=12 RGB444, DW=8 RGB332)
//   frame_done      one-cycle pulse when a captured frame ends
//   frame_err       error status of the last completed frame
//   frame_cnt       completed frame count, wraps 255 -> 0
module cam_capture_scaled #(
    parameter int AW       = 15,
    parameter int DW       = 12,
    parameter int IN_W     = 640,
    parameter int IN_H     = 480,
    parameter int DEC_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    CAM_px_data,
    input  logic          CAM_href,
    input  logic          CAM_vsync,
    input  logic          capture_en,
    input  logic [1:0]    mode,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done,
    output logic          frame_err,
    output logic [7:0]    frame_cnt
);
    localparam int OUT_W = IN_W >> DEC_LOG2;
    localparam int OUT_H = IN_H >> DEC_LOG2;
    localparam int CW    = $clog2(IN_W + 1);
    localparam int RW    = $clog2(IN_H + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(OUT_W * OUT_H - 1);
    localparam logic [CW-1:0] COL_END   = CW'(IN_W);
    localparam logic [RW-1:0] ROW_END   = RW'(IN_H);
    localparam logic [CW-1:0] COL_MASK  = CW'((1 << DEC_LOG2) - 1);
    localparam logic [RW-1:0] ROW_MASK  = RW'((1 << DEC_LOG2) - 1);

    typedef enum logic {S_WAIT, S_ACTIVE} state_t;

    state_t        state_q, state_d;
    logic          vsync_q, href_q;
    logic [1:0]    mode_q, mode_d;
    logic          phase_q, phase_d;
    logic [7:0]    b0_q, b0_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_acc_q, err_acc_d;
    logic          regw_q, regw_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    cnt_q, cnt_d;

    logic fs, fe;
    logic active, start, end_frame, busy, byte0, pix, line_end;
    logic in_range, keep;
    logic [11:0]   p12;
    logic [DW-1:0] pix_dw;

    assign fs = vsync_q & ~CAM_vsync;
    assign fe = ~vsync_q & CAM_vsync;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_WAIT;
        else
            state_q <= state_d;
    end

    // FSM: next state; a frame start while active just restarts the frame
    always_comb begin
        state_d = (state_q == S_WAIT) ? ((fs && capture_en) ? S_ACTIVE : S_WAIT)
                                      : (fe ? S_WAIT : S_ACTIVE);
    end

    // FSM: control strobes; frame sync edges take priority over line data
    always_comb begin
        active    = (state_q == S_ACTIVE);
        start     = fs && (active || capture_en);
        end_frame = active && fe;
        busy      = active && !fs && !fe;
        byte0     = busy && CAM_href && !phase_q;
        pix       = busy && CAM_href && phase_q;
        line_end  = busy && href_q && !CAM_href;
    end

    // Colour conversion of the pixel formed from {b0, current byte}
    always_comb begin
        p12 = (mode_q == 2'd1) ? {b0_q[3:0], CAM_px_data} :
              (mode_q == 2'd2) ? {3{b0_q[7:4]}} :
                                 {b0_q[7:4], b0_q[2:0], CAM_px_data[7], CAM_px_data[4:1]};
    end

    if (DW == 8) begin : g_rgb332
        assign pix_dw = {p12[11:9], p12[7:5], p12[3:2]};
    end else begin : g_rgb444
        assign pix_dw = p12;
    end

    // Datapath next state
    always_comb begin
        in_range  = (col_q < COL_END) && (row_q < ROW_END);
        keep      = pix && in_range && ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);
        mode_d    = start ? mode : mode_q;
        phase_d   = (start || line_end) ? 1'b0 : byte0 ? 1'b1 : pix ? 1'b0 : phase_q;
        b0_d      = byte0 ? CAM_px_data : b0_q;
        col_d     = (start || line_end) ? '0 :
                    (pix && col_q != COL_END) ? col_q + CW'(1) : col_q;
        row_d     = start ? '0 : (line_end && row_q != ROW_END) ? row_q + RW'(1) : row_q;
        // saturating so the address never leaves the OUT_W*OUT_H window
        addr_d    = start ? '0 : (keep && addr_q != LAST_ADDR) ? addr_q + AW'(1) : addr_q;
        // excess pixels, short/long lines and odd byte counts all poison the frame
        err_acc_d = start ? 1'b0 :
                    err_acc_q | (pix && !in_range) | (line_end && (phase_q || col_q != COL_END));
        regw_d    = keep;
        wr_addr_d = keep ? addr_q : wr_addr_q;
        wr_data_d = keep ? pix_dw : wr_data_q;
        done_d    = end_frame;
        ferr_d    = end_frame ? (err_acc_q || row_q != ROW_END) : ferr_q;
        cnt_d     = cnt_q + 8'(end_frame);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b1;
            href_q    <= 1'b0;
            mode_q    <= '0;
            phase_q   <= 1'b0;
            b0_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            err_acc_q <= 1'b0;
            regw_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            vsync_q   <= CAM_vsync;
            href_q    <= CAM_href;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            b0_q      <= b0_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            err_acc_q <= err_acc_d;
            regw_q    <= regw_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign DP_RAM_regW    = regw_q;
    assign DP_RAM_addr_in = wr_addr_q;
    assign DP_RAM_data_in = wr_data_q;
    assign frame_done     = done_q;
    assign frame_err      = ferr_q;
    assign frame_cnt      = cnt_q;
endmodule

// File: tb/tb_cam_capture_scaled.sv
// tb_cam_capture_scaled: directed, table-driven check of cam_capture_scaled
// at IN_W=8, IN_H=4, DEC_LOG2=1, AW=3 with DW=12 and DW=8 instances.
module tb_cam_capture_scaled;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] CAM_px_data = 8'h00;
    logic       CAM_href = 1'b0;
    logic       CAM_vsync = 1'b1;
    logic       capture_en = 1'b0;
    logic [1:0] mode = 2'd0;

    logic        regw, done, ferr;
    logic [2:0]  addr;
    logic [11:0] data;
    logic [7:0]  cnt;
    logic        regw8, done8, ferr8;
    logic [2:0]  addr8;
    logic [7:0]  data8, cnt8;

    cam_capture_scaled #(.AW(3), .DW(12), .IN_W(8), .IN_H(4), .DEC_LOG2(1)) u_dut (
        .clk(clk), .rst(rst), .CAM_px_data(CAM_px_data), .CAM_href(CAM_href),
        .CAM_vsync(CAM_vsync), .capture_en(capture_en), .mode(mode),
        .DP_RAM_regW(regw), .DP_RAM_addr_in(addr), .DP_RAM_data_in(data),
        .frame_done(done), .frame_err(ferr), .frame_cnt(cnt)
    );

    cam_capture_scaled #(.AW(3), .DW(8), .IN_W(8), .IN_H(4), .DEC_LOG2(1)) u_dut8 (
        .clk(clk), .rst(rst), .CAM_px_data(CAM_px_data), .CAM_href(CAM_href),
        .CAM_vsync(CAM_vsync), .capture_en(capture_en), .mode(mode),
        .DP_RAM_regW(regw8), .DP_RAM_addr_in(addr8), .DP_RAM_data_in(data8),
        .frame_done(done8), .frame_err(ferr8), .frame_cnt(cnt8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        en;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          short_row;
        int          odd_row;
        logic        mid;
        int          exp_w;
        logic [11:0] exp_d;
        logic [7:0]  exp_d8;
        logic        exp_err;
    } vec_t;

    vec_t vt [8];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;

    // write/done log captured on the falling edge
    int          nw = 0;
    int          nd = 0;
    logic [2:0]  wa  [1024];
    logic [11:0] wd  [1024];
    logic [7:0]  wd8 [1024];

    always @(negedge clk) begin
        if (regw && nw < 1024) begin
            wa[nw]  = addr;
            wd[nw]  = data;
            wd8[nw] = data8;
            nw++;
        end
        if (done) nd++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // present one input set for exactly one rising edge, return 1 time unit after it
    task automatic drive(input logic h, input logic v, input logic [7:0] d);
        CAM_href = h;
        CAM_vsync = v;
        CAM_px_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        int dbase;
        int nwr;
        base = nw;
        dbase = nd;
        capture_en = v.en;
        mode = v.mode;
        repeat (2) drive(1'b0, 1'b1, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < ((r == v.short_row) ? 7 : 8); p++) begin
                drive(1'b1, 1'b0, v.b0);
                drive(1'b1, 1'b0, v.b1);
            end
            if (r == v.odd_row) drive(1'b1, 1'b0, v.b0);
            repeat (2) drive(1'b0, 1'b0, 8'h00);
            if (v.mid && r == 0) begin
                capture_en = 1'b0;
                mode = 2'd2;
            end
        end
        repeat (3) drive(1'b0, 1'b1, 8'h00);
        if (v.en) exp_cnt++;
        nwr = nw - base;
        chk({tag, " writes"}, nwr, v.exp_w);
        for (int k = 0; k < nwr && k < 8; k++) begin
            chk($sformatf("%s addr%0d", tag, k), int'(wa[base + k]), k);
            chk($sformatf("%s data%0d", tag, k), int'(wd[base + k]), int'(v.exp_d));
            chk($sformatf("%s data8_%0d", tag, k), int'(wd8[base + k]), int'(v.exp_d8));
        end
        chk({tag, " done"}, nd - dbase, v.en ? 1 : 0);
        chk({tag, " err"}, int'(ferr), int'(v.exp_err));
        chk({tag, " cnt"}, int'(cnt), exp_cnt % 256);
    endtask

    task automatic quick_frame();
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        exp_cnt++;
    endtask

    initial begin
        int base;
        vt[0] = '{mode:2'd0, en:1'b1, b0:8'hF8, b1:8'h1F, short_row:-1, odd_row:-1, mid:1'b0,
                  exp_w:8, exp_d:12'hF0F, exp_d8:8'hE3, exp_err:1'b0};
        vt[1] = '{mode:2'd2, en:1'b1, b0:8'hA5, b1:8'h00, short_row:-1, odd_row:-1, mid:1'b0,
                  exp_w:8, exp_d:12'hAAA, exp_d8:8'hB6, exp_err:1'b0};
        vt[2] = '{mode:2'd1, en:1'b1, b0:8'h0F, b1:8'hF0, short_row:-1, odd_row:-1, mid:1'b0,
                  exp_w:8, exp_d:12'hFF0, exp_d8:8'hFC, exp_err:1'b0};
        vt[3] = '{mode:2'd0, en:1'b1, b0:8'hF8, b1:8'h1F, short_row:1, odd_row:-1, mid:1'b0,
                  exp_w:8, exp_d:12'hF0F, exp_d8:8'hE3, exp_err:1'b1};
        vt[4] = '{mode:2'd0, en:1'b1, b0:8'hF8, b1:8'h1F, short_row:-1, odd_row:3, mid:1'b0,
                  exp_w:8, exp_d:12'hF0F, exp_d8:8'hE3, exp_err:1'b1};
        vt[5] = '{mode:2'd3, en:1'b1, b0:8'hF8, b1:8'h1F, short_row:-1, odd_row:-1, mid:1'b0,
                  exp_w:8, exp_d:12'hF0F, exp_d8:8'hE3, exp_err:1'b0};
        vt[6] = '{mode:2'd0, en:1'b0, b0:8'hF8, b1:8'h1F, short_row:-1, odd_row:-1, mid:1'b0,
                  exp_w:0, exp_d:12'h000, exp_d8:8'h00, exp_err:1'b0};
        vt[7] = '{mode:2'd0, en:1'b1, b0:8'hF8, b1:8'h1F, short_row:-1, odd_row:-1, mid:1'b1,
                  exp_w:8, exp_d:12'hF0F, exp_d8:8'hE3, exp_err:1'b0};

        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 8'h00);
        chk("rst regW", int'(regw), 0);
        chk("rst addr", int'(addr), 0);
        chk("rst data", int'(data), 0);
        chk("rst data8", int'(data8), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(ferr), 0);
        chk("rst cnt", int'(cnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // write latency, then reset after the fifth write
        capture_en = 1'b1;
        mode = 2'd0;
        base = nw;
        repeat (2) drive(1'b0, 1'b1, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'hF8);
        chk("lat b0 regW", int'(regw), 0);
        drive(1'b1, 1'b0, 8'h1F);
        chk("lat col0 regW", int'(regw), 1);
        chk("lat col0 addr", int'(addr), 0);
        chk("lat col0 data", int'(data), 12'hF0F);
        drive(1'b1, 1'b0, 8'hF8);
        chk("lat col1 b0 regW", int'(regw), 0);
        drive(1'b1, 1'b0, 8'h1F);
        chk("lat col1 regW", int'(regw), 0);
        drive(1'b1, 1'b0, 8'hF8);
        drive(1'b1, 1'b0, 8'h1F);
        chk("lat col2 regW", int'(regw), 1);
        chk("lat col2 addr", int'(addr), 1);
        for (int p = 3; p < 8; p++) begin
            drive(1'b1, 1'b0, 8'hF8);
            drive(1'b1, 1'b0, 8'h1F);
        end
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        for (int p = 0; p < 8; p++) begin
            drive(1'b1, 1'b0, 8'hF8);
            drive(1'b1, 1'b0, 8'h1F);
        end
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 1'b0, 8'hF8);
            drive(1'b1, 1'b0, 8'h1F);
        end
        drive(1'b1, 1'b0, 8'hF8);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h1F);
        chk("mid rst writes before", nw - base, 5);
        chk("mid rst regW", int'(regw), 0);
        chk("mid rst addr", int'(addr), 0);
        chk("mid rst data", int'(data), 0);
        chk("mid rst done", int'(done), 0);
        chk("mid rst err", int'(ferr), 0);
        chk("mid rst cnt", int'(cnt), 0);
        rst = 1'b0;
        exp_cnt = 0;
        run_vec(vt[0], "after rst");

        // frame counter wrap; empty frames end with row != IN_H
        for (int i = 0; i < 254; i++) quick_frame();
        chk("cnt 255", int'(cnt), 255);
        quick_frame();
        chk("cnt wrap", int'(cnt), 0);
        chk("empty frame err", int'(ferr), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
